audio_dac_tx: RTL and testbench
===============================

# audio_dac_tx

Serial transmitter driving a dual-channel 12-bit SPI-style audio DAC (Pmod DA2 class, DAC121S101 frame format) from the 100 MHz board clock. It is the output-direction counterpart of the mic capture path: a producer (tone generator, loopback of `mic_in`, game sound effects) hands over sample pairs with a valid/ready handshake. The block buffers one pair and serialises it as one 16-bit frame on two data lines that share one sync and one serial clock.

## Interface
- `CLK_DIV`, 4: serial clock half-period in `clk` cycles, minimum 2 (4 gives 12.5 MHz).
- `GAP_CYCLES`, 2: minimum number of `clk` cycles `dac_sync_n` stays high between frames, minimum 1.
- `clk` in 1: board clock, 100 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: a sample pair is offered.
- `s_ready` out 1: the holding register is empty; reset value 1.
- `s_data_a` in 12: channel A sample.
- `s_data_b` in 12: channel B sample.
- `pd_mode` in 2: DAC power-down mode bits, sampled at frame load.
- `dac_sync_n` out 1: frame sync, active low; reset value 1.
- `dac_sclk` out 1: serial clock, idles high; reset value 1.
- `dac_din_a` out 1: serial data for channel A; reset value 0.
- `dac_din_b` out 1: serial data for channel B; reset value 0.
- `busy` out 1: high while a frame or gap is in progress; reset value 0.

## Operation
- Holding register `pend` (24 bits plus `pend_full`) sits in front of the shifter.
  - `s_ready = !pend_full`.
  - On a clock edge where `s_valid && s_ready`, `pend` captures A/B and `pend_full` is set.
  - `pend` can fill while a frame is shifting, so throughput is one pair per frame period.
- Frame word per channel, 16 bits, MSB first: `{2'b00, pd_mode, data[11:0]}`.
- FSM states:
  - IDLE: `sync_n`=1, `sclk`=1. If `pend_full`, load both shifters, clear `pend_full`, and go to SHIFT.
  - SHIFT: `sync_n`=0. Runs 16 bit periods, each `2*CLK_DIV` cycles: `sclk` high for the first half, low for the second. The bit counter decrements on each rising `sclk`.
  - GAP: `sync_n`=1, `sclk`=1. Lasts `GAP_CYCLES` cycles, then returns to IDLE. A new frame cannot begin before GAP ends.
- Data edge rules:
  - `din_*` changes only while `sclk` is high, at the start of each bit period.
  - The DAC samples on the falling edge of `sclk`.
- `busy` = (state != IDLE).
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously) and `pend` is discarded. The DAC sees an aborted frame (sync rising before the 16th falling edge), which it ignores.
- Simultaneous accept and load:
  - The load clears `pend_full` on the same edge. `s_ready` was 0 during that cycle, so no accept can collide with it.
  - `s_ready` returns to 1 on the cycle after the load.

## Timing
- Accepting edge E:
  - If idle, the FSM loads at E+1.
  - `dac_sync_n` falls, `dac_sclk`=1 and `din_*`=bit15 are all registered at E+1.
- Within the frame:
  - The k-th falling `sclk` edge (k = 1..16) occurs `(2k-1)*CLK_DIV` cycles after `sync_n` falls.
  - `din_*` updates `2*CLK_DIV` cycles after the previous update.
- `sync_n` rises together with the final `sclk` rise, `32*CLK_DIV` cycles after it fell.
- Frame period, back-to-back: `32*CLK_DIV + GAP_CYCLES + 1` cycles (the +1 is the IDLE load cycle); this is 131 cycles at the defaults.
- All outputs are registered; there are no combinational paths from inputs to DAC pins. `s_ready` is derived directly from the `pend_full` flop.

## Configuration
- `AUDIO_DAC_SIGNED_IN_EN`:
  - Defined: `s_data_*` is two's-complement. Bit 11 is inverted at `pend` capture (offset-binary conversion), so -2048 becomes 0x000, 0 becomes 0x800 and +2047 becomes 0xFFF.
  - Undefined: `s_data_*` is unsigned offset-binary and passes through unchanged (the same convention as raw `mic_in`).

## Test plan
- Single frame, defaults, macro undefined, A=0xABC, B=0x123, `pd_mode`=0 -> `sync_n` low for exactly 128 cycles. Sampling `din_a` on 16 `sclk` falls gives 0x0ABC; `din_b` gives 0x0123.
- Back-to-back: `s_valid` held high with 3 pairs -> second accepted during the first frame. Successive `sync_n` falls are 131 cycles apart; `s_ready` low only while `pend` is full.
- `pd_mode`=2'b11, A=0xFFF -> `din_a` stream is 0x3FFF. `pd_mode` changed mid-frame does not affect the current frame.
- `AUDIO_DAC_SIGNED_IN_EN` defined, A=0x800 (-2048), B=0x000 -> frames carry 0x0000 and 0x0800.
- `rst_n` pulsed low at bit 7 of a frame with `pend` full -> `sync_n`=1, `sclk`=1, `din`=0, `busy`=0 immediately. After release, `s_ready`=1 and no frame starts until a new accept.
- `CLK_DIV`=2, `GAP_CYCLES`=1 -> `sclk` period 4 cycles, `sync_n` high for 2 cycles between back-to-back frames.

Source files
------------

// File: rtl/audio_dac_tx.sv
// Dual-channel 12-bit serial DAC transmitter (DAC121S101 frame format, shared sync/sclk).
// Optional macro AUDIO_DAC_SIGNED_IN_EN: accept two's-complement samples and convert to offset-binary.
module audio_dac_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [11:0] s_data_a,
    input  logic [11:0] s_data_b,
    input  logic [1:0]  pd_mode,
    output logic        dac_sync_n,
    output logic        dac_sclk,
    output logic        dac_din_a,
    output logic        dac_din_b,
    output logic        busy
);

    localparam int DW = $clog2(2 * CLK_DIV);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] BIT_LAST  = DW'(2 * CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

`ifdef AUDIO_DAC_SIGNED_IN_EN
    localparam logic [11:0] SIGN_MASK = 12'h800;
`else
    localparam logic [11:0] SIGN_MASK = 12'h000;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t          state, state_d;
    logic [DW-1:0]   div_cnt, div_d;
    logic [3:0]      bit_cnt, bit_d;
    logic [GW-1:0]   gap_cnt, gap_d;
    logic [15:0]     sh_a, sh_a_d, sh_b, sh_b_d;
    logic            sync_q, sync_d, sclk_q, sclk_d;
    logic            din_a_q, din_a_d, din_b_q, din_b_d;
    logic [11:0]     pend_a, pend_b;
    logic            pend_full;
    logic            load;

    assign s_ready    = !pend_full;
    assign dac_sync_n = sync_q;
    assign dac_sclk   = sclk_q;
    assign dac_din_a  = din_a_q;
    assign dac_din_b  = din_b_q;
    assign busy       = (state != IDLE);

    // Holding register; a load and an accept never coincide since s_ready is low whenever a load is possible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full <= 1'b0;
            pend_a    <= '0;
            pend_b    <= '0;
        end else if (load) begin
            pend_full <= 1'b0;
        end else if (s_valid && !pend_full) begin
            pend_full <= 1'b1;
            pend_a    <= s_data_a ^ SIGN_MASK;
            pend_b    <= s_data_b ^ SIGN_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sh_a    <= '0;
            sh_b    <= '0;
            sync_q  <= 1'b1;
            sclk_q  <= 1'b1;
            din_a_q <= 1'b0;
            din_b_q <= 1'b0;
        end else begin
            state   <= state_d;
            div_cnt <= div_d;
            bit_cnt <= bit_d;
            gap_cnt <= gap_d;
            sh_a    <= sh_a_d;
            sh_b    <= sh_b_d;
            sync_q  <= sync_d;
            sclk_q  <= sclk_d;
            din_a_q <= din_a_d;
            din_b_q <= din_b_d;
        end
    end

    always_comb begin
        state_d = state;
        div_d   = div_cnt;
        bit_d   = bit_cnt;
        gap_d   = gap_cnt;
        sh_a_d  = sh_a;
        sh_b_d  = sh_b;
        sync_d  = sync_q;
        sclk_d  = sclk_q;
        din_a_d = din_a_q;
        din_b_d = din_b_q;
        load    = 1'b0;
        case (state)
            IDLE: begin
                sync_d = 1'b1;
                sclk_d = 1'b1;
                if (pend_full) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = 4'd15;
                    sh_a_d  = {2'b00, pd_mode, pend_a};
                    sh_b_d  = {2'b00, pd_mode, pend_b};
                    din_a_d = sh_a_d[15];
                    din_b_d = sh_b_d[15];
                    sync_d  = 1'b0;
                end
            end
            SHIFT: begin
                div_d = div_cnt + 1'b1;
                if (div_cnt == HALF_LAST)
                    sclk_d = 1'b0;
                // End of a bit period: sclk rises and the next bit is presented on the same edge.
                if (div_cnt == BIT_LAST) begin
                    div_d  = '0;
                    sclk_d = 1'b1;
                    if (bit_cnt == 4'd0) begin
                        state_d = GAP;
                        sync_d  = 1'b1;
                        gap_d   = '0;
                        din_a_d = 1'b0;
                        din_b_d = 1'b0;
                    end else begin
                        bit_d   = bit_cnt - 1'b1;
                        sh_a_d  = {sh_a[14:0], 1'b0};
                        sh_b_d  = {sh_b[14:0], 1'b0};
                        din_a_d = sh_a[14];
                        din_b_d = sh_b[14];
                    end
                end
            end
            GAP: begin
                gap_d = gap_cnt + 1'b1;
                if (gap_cnt == GAP_LAST)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Scoreboard bench for audio_dac_tx: default instance plus a CLK_DIV=2/GAP_CYCLES=1 instance.
module tb_audio_dac_tx;

    logic        clk = 1'b0;
    logic        rst_n, s_valid, s_ready;
    logic [11:0] s_data_a, s_data_b;
    logic [1:0]  pd_mode;
    logic        dac_sync_n, dac_sclk, dac_din_a, dac_din_b, busy;

    logic        rst1_n, s_valid1, s_ready1;
    logic        sync1, sclk1, din_a1, din_b1, busy1;

    always #5 clk = ~clk;

    audio_dac_tx dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data_a(s_data_a), .s_data_b(s_data_b), .pd_mode(pd_mode),
        .dac_sync_n(dac_sync_n), .dac_sclk(dac_sclk),
        .dac_din_a(dac_din_a), .dac_din_b(dac_din_b), .busy(busy)
    );

    audio_dac_tx #(.CLK_DIV(2), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .s_valid(s_valid1), .s_ready(s_ready1),
        .s_data_a(12'h5A5), .s_data_b(12'h3C3), .pd_mode(2'b00),
        .dac_sync_n(sync1), .dac_sclk(sclk1),
        .dac_din_a(din_a1), .dac_din_b(din_b1), .busy(busy1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] conv(input logic [11:0] x);
`ifdef AUDIO_DAC_SIGNED_IN_EN
        return x ^ 12'h800;
`else
        return x;
`endif
    endfunction

    // per: 0 = no period check, >0 = required cycles since previous sync fall, -1 = frame is expected to be aborted by reset
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          per;
    } exp_t;
    exp_t sb[$];

    // Monitor for the default instance
    int          cyc = 0, t_fall = -1, nbits = 0, nframes = 0;
    logic [15:0] cap_a, cap_b;
    logic        in_fr = 1'b0, p_sync = 1'b1, p_sclk = 1'b1;
    exp_t        e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            if (in_fr && sb.size() > 0 && sb[0].per < 0) void'(sb.pop_front());
            in_fr = 1'b0;
        end else begin
            if (p_sync && !dac_sync_n) begin
                in_fr = 1'b1;
                nbits = 0;
                nframes++;
                if (sb.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
                else if (sb[0].per > 0) check("frame_period", cyc - t_fall, sb[0].per);
                t_fall = cyc;
            end
            if (in_fr && p_sclk && !dac_sclk) begin
                cap_a = {cap_a[14:0], dac_din_a};
                cap_b = {cap_b[14:0], dac_din_b};
                nbits++;
            end
            if (in_fr && !p_sync && dac_sync_n) begin
                in_fr = 1'b0;
                check("sync_low_len", cyc - t_fall, 32'd128);
                check("sclk_falls", nbits, 32'd16);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("abort_missing", e.per < 0, 32'd0);
                    check("frame_a", cap_a, e.a);
                    check("frame_b", cap_b, e.b);
                end
            end
        end
        p_sync = dac_sync_n;
        p_sclk = dac_sclk;
    end

    // Monitor for the CLK_DIV=2 / GAP_CYCLES=1 instance
    int          cyc1 = 0, t1_fall = -1, t1_rise = -1, t1_sfall = -1, n1 = 0, frames1 = 0;
    logic [15:0] cap1;
    logic        in1 = 1'b0, p1_sync = 1'b1, p1_sclk = 1'b1;

    always @(negedge clk) begin
        cyc1++;
        if (rst1_n) begin
            if (p1_sync && !sync1) begin
                if (t1_rise >= 0) check("div2_sync_high", cyc1 - t1_rise, 32'd2);
                t1_fall  = cyc1;
                t1_sfall = -1;
                n1       = 0;
                in1      = 1'b1;
            end
            if (in1 && p1_sclk && !sclk1) begin
                if (t1_sfall >= 0) check("div2_sclk_period", cyc1 - t1_sfall, 32'd4);
                t1_sfall = cyc1;
                cap1 = {cap1[14:0], din_a1};
                n1++;
            end
            if (in1 && !p1_sync && sync1) begin
                in1 = 1'b0;
                check("div2_sync_low_len", cyc1 - t1_fall, 32'd64);
                check("div2_frame_a", cap1, {4'h0, conv(12'h5A5)});
                t1_rise = cyc1;
                frames1++;
            end
        end
        p1_sync = sync1;
        p1_sclk = sclk1;
    end

    logic dut1_done = 1'b0;
    initial begin
        rst1_n   = 1'b0;
        s_valid1 = 1'b0;
        #23 rst1_n = 1'b1;
        s_valid1 = 1'b1;
        repeat (250) @(posedge clk);
        #1 s_valid1 = 1'b0;
        repeat (200) @(posedge clk);
        dut1_done = 1'b1;
    end

    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [1:0] pd);
        logic ok = 1'b0;
        s_data_a = a;
        s_data_b = b;
        pd_mode  = pd;
        s_valid  = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
        end
        #1 s_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_sync_low();
        logic ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk);
            #1 ok = !dac_sync_n;
        end
        if (!ok) check("sync_fall_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        logic ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk);
            #1 ok = (sb.size() == 0) && !busy && s_ready;
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    int n0;

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data_a = '0;
        s_data_b = '0;
        pd_mode  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sync_n", dac_sync_n, 1);
        check("rst_sclk", dac_sclk, 1);
        check("rst_din_a", dac_din_a, 0);
        check("rst_din_b", dac_din_b, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame with load latency
        sb.push_back('{16'h0ABC, 16'h0123, 0});
        send(12'hABC, 12'h123, 2'b00);
        check("accept_s_ready", s_ready, 0);
        check("accept_sync_n", dac_sync_n, 1);
        @(posedge clk);
        #1;
        check("load_sync_n", dac_sync_n, 0);
        check("load_sclk", dac_sclk, 1);
        check("load_busy", busy, 1);
        check("load_s_ready", s_ready, 1);
        wait_done();

        // Back-to-back: second pair accepted during the first frame
        sb.push_back('{16'h0111, 16'h0222, 0});
        sb.push_back('{16'h0333, 16'h0444, 131});
        sb.push_back('{16'h0FED, 16'h00F0, 131});
        send(12'h111, 12'h222, 2'b00);
        check("b2b_full1", s_ready, 0);
        @(posedge clk);
        #1 check("b2b_loaded1", s_ready, 1);
        send(12'h333, 12'h444, 2'b00);
        check("b2b_full2", s_ready, 0);
        repeat (120) @(posedge clk);
        #1 check("b2b_held2", s_ready, 0);
        send(12'hFED, 12'h0F0, 2'b00);
        wait_done();

        // pd_mode sampled at load only
        sb.push_back('{16'h3FFF, 16'h3000, 0});
        send(12'hFFF, 12'h000, 2'b11);
        wait_sync_low();
        pd_mode = 2'b00;
        wait_done();

        // Signed-input conversion (pass-through when the macro is undefined)
        sb.push_back('{{4'h0, conv(12'h800)}, {4'h0, conv(12'h000)}, 0});
        send(12'h800, 12'h000, 2'b00);
        wait_done();

        // Reset in bit 7 with pend full
        sb.push_back('{16'h0FFF, 16'h0FFF, -1});
        send(12'hFFF, 12'hFFF, 2'b00);
        wait_sync_low();
        send(12'hAAA, 12'h555, 2'b00);
        repeat (66) @(posedge clk);
        #1;
        check("pre_rst_pend_full", s_ready, 0);
        check("pre_rst_din_a", dac_din_a, 1);
        rst_n = 1'b0;
        #2;
        check("abort_sync_n", dac_sync_n, 1);
        check("abort_sclk", dac_sclk, 1);
        check("abort_din_a", dac_din_a, 0);
        check("abort_din_b", dac_din_b, 0);
        check("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_sb_empty", sb.size(), 0);
        n0 = nframes;
        repeat (300) @(posedge clk);
        #1;
        check("post_rst_no_frame", nframes, n0);
        check("post_rst_busy", busy, 0);

        for (int i = 0; i < 2000 && !dut1_done; i++) @(posedge clk);
        check("div2_done", dut1_done, 1);
        check("div2_frames_ge3", frames1 >= 3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
